// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder byte memory: controller states and the
// default address width used across the SoC.
package mem_responder_pkg;

    localparam int unsigned DefaultAddrWidth = 9;

    // StClear zeroes the array one byte per cycle; StReady serves initiator accesses.
    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } state_e;

endpackage

// File: rtl/byte_ram.sv
// Single-clock byte RAM with one read and one write port. The read is registered
// and returns the pre-write contents on an address collision (read-before-write).
// The array has no reset so it maps onto block RAM.
module byte_ram
    import mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth = DefaultAddrWidth
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [7:0]           wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [7:0]           rdata_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [7:0] mem_q [Depth];
    logic [7:0] rdata_q;

    // Write on strobe; the read samples the array before this edge's write lands.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Byte memory responder. After reset it sweeps every address writing 0x00, then
// raises mem_ready and serves one read and one write per cycle until the next reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned addr_width = DefaultAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            mem_data_in,
    output logic [7:0]            mem_data_out,
    input  logic [addr_width-1:0] mem_raddr,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic                  mem_write,
    output logic                  mem_ready
);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   clear_addr_q, clear_addr_d;
    // Set when the RAM's registered read came from an edge taken in StReady.
    logic                    rd_valid_q;

    logic                    ram_we;
    logic [addr_width-1:0]   ram_waddr;
    logic [7:0]              ram_wdata;
    logic [7:0]              ram_rdata;

    // Next-state and write-port mux: the clear sweep owns the write port until done.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        ram_we       = mem_write;
        ram_waddr    = mem_waddr;
        ram_wdata    = mem_data_in;
        case (state_q)
            StClear: begin
                ram_we       = 1'b1;
                ram_waddr    = clear_addr_q;
                ram_wdata    = 8'h00;
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == '1) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    // State, sweep pointer and read-valid flag; reset restarts the whole sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            clear_addr_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            rd_valid_q   <= (state_q == StReady);
        end
    end

    byte_ram #(
        .AddrWidth (addr_width)
    ) u_byte_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (ram_rdata)
    );

    // Reads captured during the sweep may hit uninitialised storage, so force 0x00.
    assign mem_data_out = rd_valid_q ? ram_rdata : 8'h00;
    assign mem_ready    = (state_q == StReady);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (addr_width=4). The driver pushes the expected
// response for every cycle into a queue; the monitor pops and compares on the
// falling edge after the DUT has registered that cycle's read.
module tb_mem_responder;

    localparam int AW    = 4;
    localparam int Depth = 16;

    logic          clk;
    logic          reset;
    logic [7:0]    mem_data_in;
    logic [7:0]    mem_data_out;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic          mem_write;
    logic          mem_ready;

    mem_responder #(
        .addr_width (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready)
    );

    typedef struct packed {
        logic [7:0]    data;
        logic          ready;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model [Depth];
    int         edges;
    int         tests;
    int         fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory reads back as all zeros after any reset, because the clear
    // sweep zeroes every byte and initiator writes are ignored until it finishes.
    // Edge k after reset release: mem_ready is high from edge 16, reads and writes
    // are served from edge 17 on (earlier reads return 0x00).
    task automatic step(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic we, input logic [7:0] wd);
        exp_t e;
        mem_raddr   = ra;
        mem_waddr   = wa;
        mem_write   = we;
        mem_data_in = wd;
        edges++;
        e.addr  = ra;
        e.ready = (edges >= Depth);
        e.data  = (edges > Depth) ? model[ra] : 8'h00;
        exp_q.push_back(e);
        if (edges > Depth && we) begin
            model[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        tests++;
        if (mem_ready !== 1'b0 || mem_data_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b data=%02h, expected ready=0 data=00",
                     mem_ready, mem_data_out);
        end
        exp_q.delete();
        for (int i = 0; i < Depth; i++) begin
            model[i] = 8'h00;
        end
        edges = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: the head entry is checked once a newer one shows it has been clocked.
    always @(negedge clk) begin
        if (exp_q.size() > 1) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (mem_data_out !== mon_e.data || mem_ready !== mon_e.ready) begin
                fails++;
                $display("FAIL read addr=%0d: got data=%02h ready=%b, expected data=%02h ready=%b",
                         mon_e.addr, mem_data_out, mem_ready, mon_e.data, mon_e.ready);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests       = 0;
        fails       = 0;
        edges       = 0;
        reset       = 1'b1;
        mem_raddr   = '0;
        mem_waddr   = '0;
        mem_write   = 1'b0;
        mem_data_in = 8'h00;

        do_reset();

        // Writes of 0xFF to address 2 during the sweep must not land.
        for (int i = 0; i < Depth; i++) begin
            step(AW'(i), AW'(2), 1'b1, 8'hFF);
        end
        // Whole array reads back zero.
        for (int i = 0; i < Depth; i++) begin
            step(AW'(i), AW'(0), 1'b0, 8'h00);
        end
        // Write then read back.
        step(AW'(0), AW'(3), 1'b1, 8'hA5);
        step(AW'(3), AW'(0), 1'b0, 8'h00);
        // Same-cycle read/write collision returns old data first.
        step(AW'(0), AW'(7), 1'b1, 8'h11);
        step(AW'(7), AW'(7), 1'b1, 8'h5A);
        step(AW'(7), AW'(0), 1'b0, 8'h00);
        step(AW'(7), AW'(0), 1'b0, 8'h00);
        // Reset part-way through the sweep restarts it and loses prior contents.
        step(AW'(0), AW'(9), 1'b1, 8'h3C);
        step(AW'(9), AW'(0), 1'b0, 8'h00);
        step(AW'(9), AW'(0), 1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(AW'(9), AW'(9), 1'b1, 8'h77);
        end
        do_reset();
        for (int i = 0; i < Depth; i++) begin
            step(AW'(9), AW'(9), 1'b1, 8'h3C);
        end
        step(AW'(9), AW'(0), 1'b0, 8'h00);
        step(AW'(9), AW'(0), 1'b0, 8'h00);

        // Random traffic with one reset in the middle of READY.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
            end
            step(AW'($urandom_range(Depth - 1)), AW'($urandom_range(Depth - 1)),
                 1'($urandom_range(1)), 8'($urandom_range(255)));
        end
        step(AW'(0), AW'(0), 1'b0, 8'h00);
        step(AW'(0), AW'(0), 1'b0, 8'h00);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter addr_width, default 9: byte address width; the memory depth is 2**addr_width bytes.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port mem_data_in, input, 8 bits: write data from the initiator.
REQ-005 SHALL have port mem_data_out, output, 8 bits: registered read data to the initiator.
REQ-006 SHALL have port mem_raddr, input, addr_width bits: read byte address.
REQ-007 SHALL have port mem_waddr, input, addr_width bits: write byte address.
REQ-008 SHALL have port mem_write, input, 1 bit: write strobe, one byte per cycle while high.
REQ-009 SHALL have port mem_ready, output, 1 bit: high once initialisation is complete and the memory serves accesses.

Function
REQ-010 SHALL implement a two-state machine with states CLEAR and READY.
REQ-011 In CLEAR, SHALL write 0x00 to address clear_addr on every cycle and then increment clear_addr.
REQ-012 SHALL leave CLEAR when the write to clear_addr == all-ones completes; the next state is READY.
REQ-013 SHALL start READY 2**addr_width cycles after reset deasserts; mem_ready rises in the first READY cycle.
REQ-014 In CLEAR, SHALL ignore mem_write (no initiator write lands) and SHALL hold mem_data_out at 0x00.
REQ-015 In READY, SHALL set mem_data_out to mem[mem_raddr] at each rising edge, using the mem_raddr sampled at that edge.
REQ-016 Read latency SHALL be one cycle: an address presented before edge N yields data valid after edge N, so an initiator that registers the address and waits one cycle reads correct data.
REQ-017 In READY, SHALL write mem_data_in to mem[mem_waddr] on every edge where mem_write=1.
REQ-018 Back-to-back writes on consecutive cycles SHALL each land at their own address; there is no write throttling.
REQ-019 On a same-cycle read and write to the same address, SHALL return the old data (read-before-write); the new data is visible from the following cycle.
REQ-020 Addresses SHALL be used modulo 2**addr_width; no out-of-range condition exists.
REQ-021 SHALL hold mem_data_out stable while mem_raddr is unchanged and no write targets that address.
REQ-022 Once in READY, SHALL stay in READY; the only return to CLEAR is through reset.

Reset
REQ-023 On reset assertion, SHALL asynchronously force state=CLEAR, clear_addr=0, mem_ready=0 and mem_data_out=0x00.
REQ-024 Reset mid-CLEAR or mid-READY SHALL restart the full clear sequence; all prior contents are zeroed before mem_ready rises again.
REQ-025 The storage array itself SHALL NOT have a reset; it is initialised only by the CLEAR sequence.

Structure
REQ-026 SHALL place the CLEAR/READY state encodings and the default address width in the shared package used by the SoC.
REQ-027 SHALL use exactly one sub-module, byte_ram: a single-clock, one-read/one-write, read-before-write byte RAM inferable as block RAM.
REQ-028 The write port of byte_ram SHALL be driven by a multiplexer: clear_addr/0x00/always-enabled in CLEAR, mem_waddr/mem_data_in/mem_write in READY.

Verification (addr_width=4)
REQ-029 Reset pulse -> mem_ready=0 for exactly 16 cycles after deassertion, then 1; mem_data_out=0x00 throughout CLEAR.
REQ-030 After ready, read addresses 0..15 -> every read returns 0x00 one cycle after the address.
REQ-031 Write 0xA5 at address 3, then read address 3 -> mem_data_out=0xA5 one cycle after the read address.
REQ-032 Same cycle: write 0x5A to address 7 (previously 0x11) and read address 7 -> 0x11; the following cycle returns 0x5A.
REQ-033 mem_write=1 with 0xFF at address 2 during CLEAR -> address 2 reads 0x00 after ready.
REQ-034 Write 0x3C at address 9, then reset at clear_addr=5 -> 16 more clear cycles, and address 9 reads 0x00.
